huffman_merge_sequencer: RTL and testbench
==========================================

Name: huffman_merge_sequencer

Overview:
- Control FSM that drives the Huffman priority-queue/table datapath through a full tree build: one INIT, then (sym_count-1) MERGE/REORDER pairs, then root capture.
- Sits between the top-level start/config logic and the queue datapath.
- Owns merge counting, the combined-frequency sum, overflow/timeout detection and done signalling; the datapath only executes single operations.

Parameters:
- NUM_SYMS, 6, maximum leaf count supported by the queue.
- FREQ_W, 32, frequency width.
- POS_W, 8, queue-position / count width.
- TIMEOUT, 64, max cycles from op acceptance to dp_done before abort.

Ports:
- clk  in  1  clock.
- ctrl_reset  in  1  synchronous active-high reset.
- ctrl_start  in  1  level; sampled only in IDLE; rising-edge detected internally.
- sym_count  in  POS_W  number of valid leaves; latched on start.
- dp_op_valid  out  1  op request to datapath.
- dp_op  out  2  0=INIT, 1=MERGE, 2=REORDER, 3=reserved (never driven).
- dp_op_ready  in  1  datapath accepts op.
- dp_done  in  1  one-cycle pulse: accepted op complete.
- dp_min0_freq  in  FREQ_W  smallest head frequency (queue pos 0).
- dp_min1_freq  in  FREQ_W  second-smallest head frequency (pos 1).
- merged_freq  out  FREQ_W  registered min0+min1, valid while dp_op==MERGE is pending.
- merge_idx  out  POS_W  merges completed so far.
- root_freq  out  FREQ_W  final tree weight.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at end (normal or abort).
- err_count  out  1  sticky: sym_count==0 or sym_count>NUM_SYMS.
- err_ovf  out  1  sticky: min0+min1 overflowed FREQ_W.
- err_timeout  out  1  sticky: dp_done not seen within TIMEOUT.

Behaviour:
- Reset: all outputs 0, FSM→IDLE, counters 0. Reset mid-operation drops dp_op_valid the next cycle; no further ops issued.
- Sticky errors clear only on reset or on the next accepted start.
- States: IDLE, CHK_CFG, ISSUE, WAIT, NEXT, FETCH, FINISH.
- IDLE: on ctrl_start rising edge latch sym_count, clear errors and merge_idx, go CHK_CFG. ctrl_start while busy is ignored.
- CHK_CFG: if sym_count is 0 or >NUM_SYMS: set err_count, go FINISH (root_freq=0, no ops issued). Otherwise set op=INIT, go ISSUE.
- ISSUE: dp_op_valid=1 and dp_op held stable until the cycle dp_op_ready=1 (transfer). dp_op_valid=0 from the next cycle. Go WAIT; watchdog cleared.
- WAIT: watchdog increments each cycle.
  - dp_done=1 → NEXT.
  - watchdog reaches TIMEOUT → err_timeout=1, go FINISH (root_freq unchanged).
  - dp_done during ISSUE or any other state is ignored.
- NEXT, by completed op:
  - INIT → if sym_count==1 go FINISH, else FETCH.
  - MERGE → op=REORDER, go ISSUE.
  - REORDER → merge_idx++. If merge_idx (new)==sym_count-1 go FINISH, else FETCH.
- FETCH: sum is computed FREQ_W+1 wide.
  - merged_freq = sum[FREQ_W-1:0].
  - A carry sets err_ovf; the build continues with the truncated value.
  - op=MERGE, go ISSUE. merged_freq holds until the next FETCH.
- FINISH: if no error, root_freq=dp_min0_freq. done=1 for one cycle, go IDLE.
- Latency with an always-ready, 1-cycle-done datapath:
  - per INIT: ISSUE+WAIT+NEXT = 3 cycles;
  - per merge: FETCH + 2×3 = 7 cycles;
  - total = 1 (CHK_CFG) + 3 + 7·(n-1) + 1 (FINISH) cycles from the start-edge sample to the done pulse.
  - n=6 → 40 cycles.

Decomposition:
- Shared package huffman_pkg:
  - op encodings OP_INIT/OP_MERGE/OP_REORDER;
  - FSM state enum;
  - NUM_SYMS/FREQ_W/POS_W defaults, also used by the queue and table builder.
- One natural sub-module: huffman_op_watchdog (counter, clear/enable inputs, timeout pulse), reusable by later encoder controllers.

Test Plan:
- Reference datapath model with freqs {5,9,12,13,16,45}, sym_count=6, always ready, done after 1 cycle → merged_freq sequence 14,25,30,55,100. merge_idx ends at 5, root_freq=100, done at cycle 40, no errors.
- Same test with dp_op_ready held low 3 cycles on every op → dp_op_valid/dp_op stable throughout; identical results; done later by 3 cycles per op (33 extra).
- sym_count=0 and sym_count=7 → err_count=1, zero dp_op_valid cycles, done after 2 cycles, root_freq=0.
- sym_count=1, min0=42 → INIT only, root_freq=42, merge_idx=0.
- Model withholds dp_done after the 2nd MERGE → err_timeout after 64 cycles, done pulse, busy=0. A restart clears err_timeout.
- min0=0xFFFF_FFF0, min1=0x20 → err_ovf=1, merged_freq=0x10. Separately, assert ctrl_reset during WAIT → next cycle all outputs 0, IDLE.

Source files
------------

// File: rtl/huffman_pkg.sv
// Shared Huffman encoder definitions: datapath op codes, sequencer states and
// default sizing used by the queue, table builder and merge sequencer.
package huffman_pkg;

  localparam int NUM_SYMS = 6;
  localparam int FREQ_W   = 32;
  localparam int POS_W    = 8;
  localparam int TIMEOUT  = 64;

  typedef enum logic [1:0] {
    OP_INIT    = 2'd0,
    OP_MERGE   = 2'd1,
    OP_REORDER = 2'd2,
    OP_RSVD    = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHK_CFG = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_NEXT    = 3'd4,
    ST_FETCH   = 3'd5,
    ST_FINISH  = 3'd6
  } state_e;

  // Two head frequencies summed one bit wider so the carry is visible.
  function automatic logic [FREQ_W:0] freq_sum(input logic [FREQ_W-1:0] a,
                                               input logic [FREQ_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/huffman_merge_sequencer_if.sv
// Op handshake and head-frequency bus between the merge sequencer (master)
// and the priority-queue datapath (slave).
interface huffman_merge_sequencer_if #(
  parameter int FREQ_W = huffman_pkg::FREQ_W
);
  logic              dp_op_valid;
  logic [1:0]        dp_op;
  logic              dp_op_ready;
  logic              dp_done;
  logic [FREQ_W-1:0] dp_min0_freq;
  logic [FREQ_W-1:0] dp_min1_freq;

  modport master (
    output dp_op_valid, dp_op,
    input  dp_op_ready, dp_done, dp_min0_freq, dp_min1_freq
  );

  modport slave (
    input  dp_op_valid, dp_op,
    output dp_op_ready, dp_done, dp_min0_freq, dp_min1_freq
  );
endinterface

// File: rtl/huffman_op_watchdog.sv
// Cycle watchdog for an outstanding datapath op: cleared at op acceptance,
// counts while enabled and pulses timeout on the TIMEOUT-th enabled cycle.
module huffman_op_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != LAST)) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  assign timeout = en && !clr && (count_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/huffman_merge_sequencer.sv
// Control FSM sequencing INIT, (n-1) MERGE/REORDER pairs and root capture on
// the Huffman queue datapath, with config, overflow and timeout checking.
module huffman_merge_sequencer #(
  parameter int NUM_SYMS = huffman_pkg::NUM_SYMS,
  parameter int FREQ_W   = huffman_pkg::FREQ_W,
  parameter int POS_W    = huffman_pkg::POS_W,
  parameter int TIMEOUT  = huffman_pkg::TIMEOUT
) (
  input  logic                      clk,
  input  logic                      ctrl_reset,
  input  logic                      ctrl_start,
  input  logic [POS_W-1:0]          sym_count,
  huffman_merge_sequencer_if.master dp,
  output logic [FREQ_W-1:0]         merged_freq,
  output logic [POS_W-1:0]          merge_idx,
  output logic [FREQ_W-1:0]         root_freq,
  output logic                      busy,
  output logic                      done,
  output logic                      err_count,
  output logic                      err_ovf,
  output logic                      err_timeout
);
  import huffman_pkg::*;

  state_e             state_q,  state_d;
  op_e                op_q,     op_d;
  logic               start_prev_q;
  logic [POS_W-1:0]   sym_q,    sym_d;
  logic [POS_W-1:0]   idx_q,    idx_d;
  logic [FREQ_W-1:0]  merged_q, merged_d;
  logic [FREQ_W-1:0]  root_q,   root_d;
  logic               valid_q,  valid_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic               ecnt_q,   ecnt_d;
  logic               eovf_q,   eovf_d;
  logic               etmo_q,   etmo_d;

  logic               start_rise_s;
  logic               wd_clr_s;
  logic               wd_en_s;
  logic               wd_timeout_s;
  logic [FREQ_W:0]    sum_s;
  logic [POS_W-1:0]   idx_inc_s;

  assign start_rise_s = ctrl_start & ~start_prev_q;
  assign sum_s        = {1'b0, dp.dp_min0_freq} + {1'b0, dp.dp_min1_freq};
  assign idx_inc_s    = idx_q + POS_W'(1);

  huffman_op_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (ctrl_reset),
    .clr     (wd_clr_s),
    .en      (wd_en_s),
    .timeout (wd_timeout_s)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sym_d    = sym_q;
    idx_d    = idx_q;
    merged_d = merged_q;
    root_d   = root_q;
    ecnt_d   = ecnt_q;
    eovf_d   = eovf_q;
    etmo_d   = etmo_q;
    wd_clr_s = 1'b0;
    wd_en_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_rise_s) begin
          sym_d   = sym_count;
          idx_d   = '0;
          ecnt_d  = 1'b0;
          eovf_d  = 1'b0;
          etmo_d  = 1'b0;
          state_d = ST_CHK_CFG;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHK_CFG: begin
        if ((sym_q == '0) || (sym_q > POS_W'(NUM_SYMS))) begin
          ecnt_d  = 1'b1;
          root_d  = '0;
          state_d = ST_FINISH;
        end else begin
          op_d    = OP_INIT;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // valid_q is always high here, so ready alone marks the transfer
        if (dp.dp_op_ready) begin
          wd_clr_s = 1'b1;
          state_d  = ST_WAIT;
        end else begin
          state_d  = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        wd_en_s = 1'b1;
        if (dp.dp_done) begin
          state_d = ST_NEXT;
        end else if (wd_timeout_s) begin
          etmo_d  = 1'b1;
          state_d = ST_FINISH;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_NEXT: begin
        case (op_q)
          OP_INIT: begin
            if (sym_q == POS_W'(1)) begin
              state_d = ST_FINISH;
            end else begin
              state_d = ST_FETCH;
            end
          end
          OP_MERGE: begin
            op_d    = OP_REORDER;
            state_d = ST_ISSUE;
          end
          OP_REORDER: begin
            idx_d = idx_inc_s;
            if (idx_inc_s == (sym_q - POS_W'(1))) begin
              state_d = ST_FINISH;
            end else begin
              state_d = ST_FETCH;
            end
          end
          default: begin
            state_d = ST_FINISH;
          end
        endcase
      end
      ST_FETCH: begin
        // a carry is flagged but the truncated weight keeps the build going
        merged_d = sum_s[FREQ_W-1:0];
        if (sum_s[FREQ_W]) begin
          eovf_d = 1'b1;
        end else begin
          eovf_d = eovf_q;
        end
        op_d    = OP_MERGE;
        state_d = ST_ISSUE;
      end
      ST_FINISH: begin
        if (!(ecnt_q || eovf_q || etmo_q)) begin
          root_d = dp.dp_min0_freq;
        end else begin
          root_d = root_q;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    valid_d = (state_d == ST_ISSUE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_q == ST_FINISH);
  end

  always_ff @(posedge clk) begin
    if (ctrl_reset) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_INIT;
      start_prev_q <= 1'b0;
      sym_q        <= '0;
      idx_q        <= '0;
      merged_q     <= '0;
      root_q       <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ecnt_q       <= 1'b0;
      eovf_q       <= 1'b0;
      etmo_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      start_prev_q <= ctrl_start;
      sym_q        <= sym_d;
      idx_q        <= idx_d;
      merged_q     <= merged_d;
      root_q       <= root_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ecnt_q       <= ecnt_d;
      eovf_q       <= eovf_d;
      etmo_q       <= etmo_d;
    end
  end

  assign dp.dp_op_valid = valid_q;
  assign dp.dp_op       = op_q;
  assign merged_freq    = merged_q;
  assign merge_idx      = idx_q;
  assign root_freq      = root_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_count      = ecnt_q;
  assign err_ovf        = eovf_q;
  assign err_timeout    = etmo_q;
endmodule

// File: tb/tb_huffman_merge_sequencer.sv
// Bench for huffman_merge_sequencer: queue-based datapath model plus a Huffman
// reference (repeated two-smallest merge) checked every negedge.
module tb_huffman_merge_sequencer;
  import huffman_pkg::*;

  logic        clk = 1'b0;
  logic        ctrl_reset;
  logic        ctrl_start;
  logic [7:0]  sym_count;
  logic [31:0] merged_freq;
  logic [7:0]  merge_idx;
  logic [31:0] root_freq;
  logic        busy, done, err_count, err_ovf, err_timeout;

  huffman_merge_sequencer_if #(.FREQ_W(32)) dpif ();

  huffman_merge_sequencer dut (
    .clk         (clk),
    .ctrl_reset  (ctrl_reset),
    .ctrl_start  (ctrl_start),
    .sym_count   (sym_count),
    .dp          (dpif),
    .merged_freq (merged_freq),
    .merge_idx   (merge_idx),
    .root_freq   (root_freq),
    .busy        (busy),
    .done        (done),
    .err_count   (err_count),
    .err_ovf     (err_ovf),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference and datapath model state
  logic [31:0] leaves[$];
  logic [31:0] q[$];
  logic [31:0] exp_merged[$];
  logic [1:0]  exp_ops[$];
  logic [31:0] seen_merged[$];
  int          xfer_merge[$];
  logic        exp_ovf;
  logic [31:0] exp_root;
  logic [31:0] last_root = 32'd0;
  int stall_n = 0, stall_cnt = 0, withhold_after = 0, merges_done = 0;
  int op_i = 0, m_i = 0, valid_cycles = 0;
  bit pending = 1'b0, withheld = 1'b0, prev_stall = 1'b0;
  logic [1:0] pend_op, prev_op;
  int start_cyc, done_cyc;

  function automatic void expect_build(input int n);
    logic [31:0] w[$];
    logic [32:0] s;
    exp_merged.delete();
    exp_ops.delete();
    exp_ovf  = 1'b0;
    exp_root = 32'd0;
    if (n < 1 || n > 6) return;
    w = leaves;
    exp_ops.push_back(2'd0);
    for (int i = 0; i < n - 1; i++) begin
      w.sort();
      s = {1'b0, w[0]} + {1'b0, w[1]};
      exp_ovf = exp_ovf | s[32];
      exp_merged.push_back(s[31:0]);
      void'(w.pop_front());
      void'(w.pop_front());
      w.push_back(s[31:0]);
      exp_ops.push_back(2'd1);
      exp_ops.push_back(2'd2);
    end
    exp_root = w[0];
  endfunction

  // datapath model and per-cycle compare
  always @(negedge clk) begin
    logic [31:0] a, b;
    dpif.dp_done = 1'b0;
    if (pending) begin
      pending = 1'b0;
      case (pend_op)
        2'd0: begin q = leaves; q.sort(); end
        2'd1: begin
          merges_done++;
          if (withhold_after != 0 && merges_done == withhold_after) withheld = 1'b1;
          else if (q.size() >= 2) begin
            a = q.pop_front(); b = q.pop_front(); q.push_back(a + b);
          end
        end
        2'd2: q.sort();
        default: ;
      endcase
      if (!withheld) dpif.dp_done = 1'b1;
    end
    dpif.dp_min0_freq = (q.size() > 0) ? q[0] : 32'd0;
    dpif.dp_min1_freq = (q.size() > 1) ? q[1] : 32'd0;
    if (dpif.dp_op_valid) begin
      if (stall_cnt < stall_n) begin dpif.dp_op_ready = 1'b0; stall_cnt++; end
      else dpif.dp_op_ready = 1'b1;
    end else begin
      dpif.dp_op_ready = 1'b0;
    end

    if (prev_stall) begin
      chk("hold_valid", dpif.dp_op_valid, 1'b1);
      chk("hold_op", dpif.dp_op, prev_op);
    end
    prev_stall = dpif.dp_op_valid && !dpif.dp_op_ready;
    prev_op    = dpif.dp_op;
    if (dpif.dp_op_valid) valid_cycles++;

    if (dpif.dp_op_valid && dpif.dp_op_ready) begin
      chk("op_seq", dpif.dp_op, (op_i < exp_ops.size()) ? exp_ops[op_i] : 2'd3);
      op_i++;
      if (dpif.dp_op == 2'd1) begin
        seen_merged.push_back(merged_freq);
        xfer_merge.push_back(cyc + 1);
        chk("merged_freq", merged_freq, (m_i < exp_merged.size()) ? {32'd0, exp_merged[m_i]} : 64'hdead);
        m_i++;
      end
      pending   = 1'b1;
      pend_op   = dpif.dp_op;
      stall_cnt = 0;
    end
  end

  task automatic do_start(input int n);
    @(negedge clk);
    ctrl_start = 1'b1;
    sym_count  = n[7:0];
    start_cyc  = cyc + 1;
    @(negedge clk);
    ctrl_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    chk("done_seen", found, 1'b1);
    done_cyc = cyc;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, dpif.dp_op_valid, 1'b0);
    chk({tag, "_op"}, dpif.dp_op, 2'd0);
    chk({tag, "_merged"}, merged_freq, 32'd0);
    chk({tag, "_idx"}, merge_idx, 8'd0);
    chk({tag, "_root"}, root_freq, 32'd0);
    chk({tag, "_flags"}, {busy, done, err_count, err_ovf, err_timeout}, 5'b0);
  endtask

  task automatic run_build(input int n, input int stall, input int wh, input int exp_lat,
                           input logic exp_cerr, input logic exp_terr, input int exp_idx);
    expect_build(n);
    stall_n = stall; withhold_after = wh; merges_done = 0; withheld = 1'b0;
    op_i = 0; m_i = 0; valid_cycles = 0;
    seen_merged.delete(); xfer_merge.delete();
    do_start(n);
    chk("errs_cleared", {err_count, err_ovf, err_timeout}, 3'b000);
    chk("busy_after_start", busy, 1'b1);
    wait_done(400);
    if (exp_cerr) last_root = 32'd0;
    else if (!(exp_terr || exp_ovf)) last_root = exp_root;
    if (exp_lat >= 0) chk("latency", done_cyc - start_cyc, exp_lat);
    else if (xfer_merge.size() >= wh) chk("timeout_latency", done_cyc - xfer_merge[wh-1], 65);
    else chk("timeout_xfer_seen", xfer_merge.size(), wh);
    chk("root_freq", root_freq, last_root);
    chk("merge_idx", merge_idx, exp_idx);
    chk("err_count", err_count, exp_cerr);
    chk("err_ovf", err_ovf, exp_ovf);
    chk("err_timeout", err_timeout, exp_terr);
    chk("busy_at_done", busy, 1'b0);
    if (exp_cerr) chk("no_ops", valid_cycles, 0);
    @(negedge clk);
    chk("done_pulse", done, 1'b0);
  endtask

  initial begin
    logic [31:0] pins[$];
    bit seen;
    ctrl_reset = 1'b1; ctrl_start = 1'b0; sym_count = 8'd0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    ctrl_reset = 1'b0;

    leaves = {32'd5, 32'd9, 32'd12, 32'd13, 32'd16, 32'd45};
    run_build(6, 0, 0, 40, 1'b0, 1'b0, 5);
    pins = {32'd14, 32'd25, 32'd30, 32'd55, 32'd100};
    chk("pin_count", seen_merged.size(), 5);
    for (int i = 0; i < 5 && i < seen_merged.size(); i++) chk("pin_merged", seen_merged[i], pins[i]);
    chk("pin_root", root_freq, 32'd100);

    run_build(6, 3, 0, 73, 1'b0, 1'b0, 5);
    run_build(0, 0, 0, 2, 1'b1, 1'b0, 0);
    run_build(7, 0, 0, 2, 1'b1, 1'b0, 0);

    leaves = {32'd42};
    run_build(1, 0, 0, 5, 1'b0, 1'b0, 0);
    chk("pin_root_single", root_freq, 32'd42);

    leaves = {32'd5, 32'd9, 32'd12, 32'd13, 32'd16, 32'd45};
    run_build(6, 0, 2, -1, 1'b0, 1'b1, 1);

    leaves = {32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8};
    run_build(6, 0, 0, 40, 1'b0, 1'b0, 5);
    chk("pin_root_fib", root_freq, 32'd20);

    leaves = {32'hFFFF_FFF0, 32'h20};
    run_build(2, 0, 0, 12, 1'b0, 1'b0, 1);
    chk("pin_ovf_merged", merged_freq, 32'h10);
    chk("pin_ovf_flag", err_ovf, 1'b1);

    // reset while waiting on the INIT op
    leaves = {32'd5, 32'd9, 32'd12, 32'd13, 32'd16, 32'd45};
    expect_build(6);
    stall_n = 0; withhold_after = 0; op_i = 0; m_i = 0;
    do_start(6);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (dpif.dp_op_valid) seen = 1'b1;
    end
    chk("reset_test_issue", seen, 1'b1);
    @(negedge clk);
    chk("reset_test_in_wait", {busy, dpif.dp_op_valid}, 2'b10);
    ctrl_reset = 1'b1;
    @(negedge clk);
    ctrl_reset = 1'b0;
    check_zero("midreset");
    valid_cycles = 0;
    repeat (5) @(negedge clk);
    chk("midreset_no_ops", valid_cycles, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
